// File: rtl/sprite_motion_ctrl_if.sv
// Pin bundle for sprite_motion_ctrl: raw asynchronous controls in, registered
// sprite position and status out.
interface sprite_motion_ctrl_if;
  logic        i_v_sync;
  logic        btn3;
  logic        btn2;
  logic        sw;
  logic [15:0] sprite_x_pos;
  logic [15:0] sprite_y_pos;
  logic        o_frame_tick;
  logic        o_moving;
  logic [3:0]  o_at_edge;

  modport master (
    output i_v_sync, btn3, btn2, sw,
    input  sprite_x_pos, sprite_y_pos, o_frame_tick, o_moving, o_at_edge
  );

  modport slave (
    input  i_v_sync, btn3, btn2, sw,
    output sprite_x_pos, sprite_y_pos, o_frame_tick, o_moving, o_at_edge
  );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Frame-paced sprite mover: debounces button requests over v_sync ticks and
// steps the sprite with hold-time acceleration, clamped to the visible area.
//
// state | meaning
// IDLE  | no request latched, sprite at rest
// ARM   | request latched, counting stable frames in deb_cnt
// MOVE  | request debounced, sprite steps once per frame tick
module sprite_motion_ctrl #(
  parameter int SCREEN_W        = 800,
  parameter int SCREEN_H        = 600,
  parameter int SPRITE_SIZE     = 16,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int ACCEL1          = 8,
  parameter int ACCEL2          = 32
) (
  input logic clk,
  input logic rst_n,
  sprite_motion_ctrl_if.slave bus
);

  localparam logic [15:0] MAX_X = 16'(SCREEN_W - SPRITE_SIZE);
  localparam logic [15:0] MAX_Y = 16'(SCREEN_H - SPRITE_SIZE);

  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1) + 1;
  localparam int HW = $clog2(ACCEL2 + 1) + 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_FRAMES);
  localparam logic [HW-1:0] HOLD_A1  = HW'(ACCEL1);
  localparam logic [HW-1:0] HOLD_A2  = HW'(ACCEL2);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MOVE = 2'd2;

  logic [1:0]    vs_sync;
  logic [1:0]    b3_sync;
  logic [1:0]    b2_sync;
  logic [1:0]    sw_sync;
  logic          vs_dly;
  logic          frame_tick;

  logic [1:0]    state;
  logic          lat_axis;
  logic          lat_dir;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic [15:0]   pos_x;
  logic [15:0]   pos_y;

  logic          req_valid;
  logic          req_axis;
  logic          req_dir;
  logic          req_same;
  logic [DW-1:0] deb_next;
  logic [2:0]    step;
  logic [15:0]   next_x;
  logic [15:0]   next_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sync <= 2'b00;
      b3_sync <= 2'b00;
      b2_sync <= 2'b00;
      sw_sync <= 2'b00;
    end else begin
      vs_sync <= {vs_sync[0], bus.i_v_sync};
      b3_sync <= {b3_sync[0], bus.btn3};
      b2_sync <= {b2_sync[0], bus.btn2};
      sw_sync <= {sw_sync[0], bus.sw};
    end
  end

  // Registered edge detect: the tick is a clean one-cycle strobe for the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_dly     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_dly     <= vs_sync[1];
      frame_tick <= vs_sync[1] & ~vs_dly;
    end
  end

  // X request (btn3) has priority over Y request (btn2).
  always_comb begin
    req_valid = b3_sync[1] | b2_sync[1];
    req_axis  = b3_sync[1];
    req_dir   = sw_sync[1];
    req_same  = (req_axis == lat_axis) && (req_dir == lat_dir);
    deb_next  = deb_cnt + DW'(1);
  end

  always_comb begin
    if (hold_cnt < HOLD_A1) begin
      step = 3'd1;
    end else if (hold_cnt < HOLD_A2) begin
      step = 3'd2;
    end else begin
      step = 3'd4;
    end
  end

  function automatic logic [15:0] step_pos(input logic [15:0] pos,
                                           input logic [2:0]  delta,
                                           input logic        dir,
                                           input logic [15:0] lim);
    logic [16:0] sum;
    sum = {1'b0, pos} + {14'd0, delta};
    if (dir) begin
      step_pos = (sum > {1'b0, lim}) ? lim : sum[15:0];
    end else begin
      step_pos = (pos < {13'd0, delta}) ? 16'd0 : pos - {13'd0, delta};
    end
  endfunction

  always_comb begin
    next_x = pos_x;
    next_y = pos_y;
    if (lat_axis) begin
      next_x = step_pos(pos_x, step, lat_dir, MAX_X);
    end else begin
      next_y = step_pos(pos_y, step, lat_dir, MAX_Y);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      lat_axis <= 1'b0;
      lat_dir  <= 1'b0;
      deb_cnt  <= '0;
      hold_cnt <= '0;
      pos_x    <= 16'd0;
      pos_y    <= 16'd0;
    end else if (frame_tick) begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state    <= ST_ARM;
            lat_axis <= req_axis;
            lat_dir  <= req_dir;
            deb_cnt  <= DW'(1);
          end
        end
        ST_ARM: begin
          if (!req_valid) begin
            state   <= ST_IDLE;
            deb_cnt <= '0;
          end else if (!req_same) begin
            lat_axis <= req_axis;
            lat_dir  <= req_dir;
            deb_cnt  <= DW'(1);
          end else if (deb_next >= DEB_LAST) begin
            state    <= ST_MOVE;
            deb_cnt  <= deb_next;
            hold_cnt <= '0;
          end else begin
            deb_cnt <= deb_next;
          end
        end
        ST_MOVE: begin
          if (!req_valid) begin
            state   <= ST_IDLE;
            deb_cnt <= '0;
          end else if (!req_same) begin
            state    <= ST_ARM;
            lat_axis <= req_axis;
            lat_dir  <= req_dir;
            deb_cnt  <= DW'(1);
          end else begin
            pos_x <= next_x;
            pos_y <= next_y;
            if (hold_cnt < HOLD_A2) begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          deb_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.sprite_x_pos = pos_x;
  assign bus.sprite_y_pos = pos_y;
  assign bus.o_frame_tick = frame_tick;
  assign bus.o_moving     = (state == ST_MOVE);
  assign bus.o_at_edge    = {pos_x == 16'd0, pos_x == MAX_X,
                             pos_y == 16'd0, pos_y == MAX_Y};

endmodule

// File: doc/sprite_motion_ctrl.md
SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

Interface
REQ-001 Parameter SCREEN_W, default 800, visible width in pixels.
REQ-002 Parameter SCREEN_H, default 600, visible height in pixels.
REQ-003 Parameter SPRITE_SIZE, default 16, sprite edge length in pixels.
REQ-004 Parameter DEBOUNCE_FRAMES, default 3, consecutive frame ticks a request must be stable before motion.
REQ-005 Parameter ACCEL1, default 8, hold count at which step becomes 2.
REQ-006 Parameter ACCEL2, default 32, hold count at which step becomes 4.
REQ-007 clk  input  1  single block clock; all state changes on its rising edge.
REQ-008 rst_n  input  1  reset; asynchronous and active-low.
REQ-009 i_v_sync  input  1  vertical sync, asynchronous to clk.
REQ-010 btn3  input  1  X-axis move request, asynchronous.
REQ-011 btn2  input  1  Y-axis move request, asynchronous.
REQ-012 sw  input  1  direction: 1 = increment, 0 = decrement.
REQ-013 sprite_x_pos  output  16  sprite top-left X, registered.
REQ-014 sprite_y_pos  output  16  sprite top-left Y, registered.
REQ-015 o_frame_tick  output  1  one-clk pulse per detected v_sync rising edge.
REQ-016 o_moving  output  1  high while FSM is in MOVE.
REQ-017 o_at_edge  output  4  {x==0, x==MAX_X, y==0, y==MAX_Y}, from position registers.

Function
REQ-018 MAX_X SHALL be SCREEN_W-SPRITE_SIZE (784) and MAX_Y SHALL be SCREEN_H-SPRITE_SIZE (584).
REQ-019 i_v_sync, btn2, btn3 and sw SHALL each pass through a 2-FF synchronizer before use.
REQ-020 o_frame_tick SHALL pulse for exactly one clk on the synchronized v_sync 0->1 transition, 3 clk after the raw edge is captured.
REQ-021 FSM state, counters and positions SHALL change only in o_frame_tick cycles.
REQ-022 Request SHALL be X-axis if btn3 is high, else Y-axis if btn2 is high, else none; direction SHALL be sw; btn3 wins when both are high.
REQ-023 FSM states SHALL be IDLE, ARM and MOVE.
REQ-024 IDLE: on a tick with a request, go to ARM, latch axis and direction, deb_cnt=1.
REQ-025 ARM: no request -> IDLE; request differing in axis or direction -> stay in ARM, relatch, deb_cnt=1; same request -> deb_cnt+1, and if that reaches DEBOUNCE_FRAMES -> MOVE with hold_cnt=0 and no position change.
REQ-026 MOVE: same request -> move latched axis by step, then hold_cnt+1 (saturating at ACCEL2); no request -> IDLE; changed request -> ARM, relatch, deb_cnt=1, no movement.
REQ-027 Step SHALL be 1 if hold_cnt<ACCEL1, 2 if hold_cnt<ACCEL2, else 4, using hold_cnt before increment.
REQ-028 Increment SHALL clamp to MAX_X/MAX_Y; decrement SHALL clamp to 0; no wrap-around.
REQ-029 A clamped position SHALL hold at the bound on further ticks while FSM stays in MOVE.
REQ-030 The non-selected axis position SHALL never change.

Reset
REQ-031 While rst_n is low: sprite_x_pos=0, sprite_y_pos=0, state IDLE, deb_cnt=0, hold_cnt=0, synchronizers=0, o_frame_tick=0, o_moving=0.
REQ-032 At reset, o_at_edge SHALL read 4'b1010.
REQ-033 Reset asserted mid-MOVE SHALL take effect immediately, without waiting for clk or tick.
REQ-034 After release, the first tick SHALL be treated as coming from IDLE.

Verification
REQ-035 btn3=1, sw=1 held from reset -> ticks 1-3 no motion, o_moving rises after tick 3, x=1 after tick 4, x=8 after tick 11, x=10 after tick 12.
REQ-036 btn3 held with sw=1 for 300 ticks -> x clamps at 784, o_at_edge[2]=1, o_moving stays 1; sw=0 with btn3 held -> ARM, 3 ticks no motion, then x=783.
REQ-037 btn2=1, sw=0 at y=0 -> y stays 0 through MOVE, o_at_edge[1]=1, x unchanged.
REQ-038 btn2 and btn3 both high, sw=1 -> only x moves; btn3 drops after 2 ticks in ARM -> relatch to Y, deb_cnt=1, y moves first on the 4th tick after the change.
REQ-039 btn3 pulse lasting 2 ticks -> FSM returns to IDLE, x unchanged (debounce rejection).
REQ-040 rst_n low for one clk mid-MOVE, between ticks -> positions 0, o_moving=0 asynchronously; next tick with btn3 held -> ARM, deb_cnt=1.
